// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and keyboard-response helper for the PS/2 key encoder.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_RSP_00 = 8'h00;
  localparam logic [7:0] PS2_RSP_AA = 8'hAA;
  localparam logic [7:0] PS2_RSP_EE = 8'hEE;
  localparam logic [7:0] PS2_RSP_FA = 8'hFA;
  localparam logic [7:0] PS2_RSP_FE = 8'hFE;
  localparam logic [7:0] PS2_RSP_FF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  // Bytes the keyboard sends as protocol responses rather than key codes.
  function automatic logic is_kbd_response(input logic [7:0] b);
    logic r;
    case (b)
      PS2_RSP_00, PS2_RSP_AA, PS2_RSP_EE,
      PS2_RSP_FA, PS2_RSP_FE, PS2_RSP_FF: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a debounce counter for one PS/2 line.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic i_line,
  output logic o_line
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_filt;

  // Level only follows the synchronized input after FILTER_LEN disagreeing samples in a row.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= 2'b11;
      r_cnt  <= {CW{1'b0}};
      r_filt <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_line};
      if (r_sync[1] == r_filt) begin
        r_cnt <= {CW{1'b0}};
      end else if (r_cnt == CNT_LAST) begin
        r_filt <= r_sync[1];
        r_cnt  <= {CW{1'b0}};
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_line = r_filt;

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard receiver producing the 11-bit toggle-format key event bus.
module ps2_key_encoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 20000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk_in,
  input  logic        ps2_dat_in,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

  logic w_clk_f;
  logic w_dat_f;
  logic w_strobe;

  ps2_state_e    r_state, w_state_nxt;
  logic [2:0]    r_bitcnt, w_bitcnt_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_par, w_par_nxt;
  logic [TW-1:0] r_tmo, w_tmo_nxt;
  logic          r_ext, w_ext_nxt;
  logic          r_brk, w_brk_nxt;
  logic [10:0]   r_key, w_key_nxt;
  logic          r_err, w_err_nxt;
  logic          r_clk_prev;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .i_line  (ps2_clk_in),
    .o_line  (w_clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .i_line  (ps2_dat_in),
    .o_line  (w_dat_f)
  );

  assign w_strobe = r_clk_prev & ~w_clk_f;

  // Frame FSM, timeout supervision and byte decode into the event bus.
  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_par_nxt    = r_par;
    w_tmo_nxt    = r_tmo;
    w_ext_nxt    = r_ext;
    w_brk_nxt    = r_brk;
    w_key_nxt    = r_key;
    w_err_nxt    = 1'b0;
    if (w_strobe) begin
      w_tmo_nxt = {TW{1'b0}};
      case (r_state)
        IDLE: begin
          if (!w_dat_f) begin
            w_state_nxt  = DATA;
            w_bitcnt_nxt = 3'd0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        DATA: begin
          w_shift_nxt = {w_dat_f, r_shift[7:1]};
          if (r_bitcnt == 3'd7) begin
            w_state_nxt = PARITY;
          end else begin
            w_bitcnt_nxt = r_bitcnt + 3'd1;
          end
        end
        PARITY: begin
          w_par_nxt   = w_dat_f;
          w_state_nxt = STOP;
        end
        STOP: begin
          w_state_nxt = IDLE;
          if (w_dat_f && (^{r_shift, r_par})) begin
            if (r_shift == PS2_EXT) begin
              w_ext_nxt = 1'b1;
            end else if (r_shift == PS2_BRK) begin
              w_brk_nxt = 1'b1;
            end else if (is_kbd_response(r_shift) && !r_ext && !r_brk) begin
              w_key_nxt = r_key;
            end else begin
              w_key_nxt = {~r_key[10], ~r_brk, r_ext, r_shift};
              w_ext_nxt = 1'b0;
              w_brk_nxt = 1'b0;
            end
          end else begin
            w_err_nxt = 1'b1;
            w_ext_nxt = 1'b0;
            w_brk_nxt = 1'b0;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end else if (r_state != IDLE) begin
      if (r_tmo == TMO_MAX) begin
        w_state_nxt = IDLE;
        w_err_nxt   = 1'b1;
        w_ext_nxt   = 1'b0;
        w_brk_nxt   = 1'b0;
      end else begin
        w_tmo_nxt = r_tmo + TW'(1);
      end
    end else begin
      w_tmo_nxt = r_tmo;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_bitcnt   <= 3'd0;
      r_shift    <= 8'd0;
      r_par      <= 1'b0;
      r_tmo      <= {TW{1'b0}};
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
      r_key      <= 11'd0;
      r_err      <= 1'b0;
      r_clk_prev <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_shift    <= w_shift_nxt;
      r_par      <= w_par_nxt;
      r_tmo      <= w_tmo_nxt;
      r_ext      <= w_ext_nxt;
      r_brk      <= w_brk_nxt;
      r_key      <= w_key_nxt;
      r_err      <= w_err_nxt;
      r_clk_prev <= w_clk_f;
    end
  end

  assign ps2_key   = r_key;
  assign frame_err = r_err;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Scoreboard bench: frames are generated from bytes, a high-level key model predicts events and errors.
module tb_ps2_key_encoder;

  localparam int TIMEOUT = 20000;
  localparam int H       = 20;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ps2_clk_in;
  logic        ps2_dat_in;
  logic [10:0] ps2_key;
  logic        frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] exp_q[$];
  bit          err_q[$];

  bit m_tog, m_ext, m_brk;

  ps2_key_encoder #(.FILTER_LEN(8), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_key    (ps2_key),
    .frame_err  (frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: scan-code protocol rules applied to whole bytes.
  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
      err_q.push_back(1'b1);
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if ((b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) && !m_ext && !m_brk) begin
      m_ext = m_ext;
    end else begin
      m_tog = ~m_tog;
      exp_q.push_back({m_tog, ~m_brk, m_ext, b});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_abort();
    m_ext = 1'b0;
    m_brk = 1'b0;
    err_q.push_back(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk_sys); #1;
      ps2_dat_in = bits[i];
      repeat (H) @(posedge clk_sys);
      #1 ps2_clk_in = 1'b0;
      repeat (H) @(posedge clk_sys);
      #1 ps2_clk_in = 1'b1;
    end
    repeat (H) @(posedge clk_sys);
    #1 ps2_dat_in = 1'b1;
    repeat (2 * H) @(posedge clk_sys);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && (exp_q.size() != 0 || err_q.size() != 0); i++) @(posedge clk_sys);
    @(negedge clk_sys);
    n_checks++;
    if (exp_q.size() != 0 || err_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_%s pending_events=%0d pending_errs=%0d expected=0", name, exp_q.size(), err_q.size());
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    model_byte(b, !(bad_par || bad_stop));
    send_frame(b, bad_par, bad_stop, 11);
    wait_drain("frame");
  endtask

  // Monitor: every change of the event bus and every error pulse is matched against the scoreboard.
  logic [10:0] mon_prev = 11'd0;
  bit          mon_err_prev = 1'b0;
  always @(negedge clk_sys) begin
    logic [10:0] e;
    if (!reset_n) begin
      mon_prev     = 11'd0;
      mon_err_prev = 1'b0;
    end else begin
      if (ps2_key !== mon_prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event actual=%h expected=no_change", ps2_key);
        end else begin
          e = exp_q.pop_front();
          if (ps2_key !== e) begin
            n_fail++;
            $display("FAIL event actual=%h expected=%h", ps2_key, e);
          end
        end
        mon_prev = ps2_key;
      end
      if (frame_err === 1'b1) begin
        n_checks++;
        if (mon_err_prev) begin
          n_fail++;
          $display("FAIL err_width actual=multi_cycle expected=single_cycle");
        end else if (err_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_err actual=1 expected=0");
        end else begin
          void'(err_q.pop_front());
        end
      end
      mon_err_prev = (frame_err === 1'b1);
    end
  end

  initial begin
    logic [7:0] b;
    logic [7:0] rsp [6];
    int sel;
    bit bp, bs;
    rsp[0] = 8'h00; rsp[1] = 8'hAA; rsp[2] = 8'hEE;
    rsp[3] = 8'hFA; rsp[4] = 8'hFE; rsp[5] = 8'hFF;
    m_tog = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
    ps2_clk_in = 1'b1;
    ps2_dat_in = 1'b1;
    reset_n    = 1'b0;
    repeat (5) @(negedge clk_sys);
    check("reset_key", ps2_key, 11'd0);
    check("reset_err", {10'd0, frame_err}, 11'd0);
    reset_n = 1'b1;
    repeat (50) @(posedge clk_sys);

    send_byte(8'h1C, 1'b0, 1'b0);
    check("make_1C", ps2_key, 11'h61C);
    send_byte(8'hF0, 1'b0, 1'b0);
    send_byte(8'h1C, 1'b0, 1'b0);
    check("break_1C", ps2_key, 11'h01C);
    send_byte(8'hE0, 1'b0, 1'b0);
    send_byte(8'h75, 1'b0, 1'b0);
    check("ext_make_75", ps2_key, 11'h775);
    send_byte(8'hE0, 1'b0, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0);
    send_byte(8'h75, 1'b0, 1'b0);
    check("ext_break_75", ps2_key, 11'h175);

    send_byte(8'h1C, 1'b1, 1'b0);
    check("parity_err_key_held", ps2_key, 11'h175);
    send_byte(8'h1C, 1'b0, 1'b0);
    check("after_parity_err", ps2_key, 11'h61C);

    model_abort();
    send_frame(8'h29, 1'b0, 1'b0, 5);
    repeat (TIMEOUT + 50) @(posedge clk_sys);
    wait_drain("timeout");
    send_byte(8'h29, 1'b0, 1'b0);
    check("after_timeout", ps2_key, 11'h229);

    @(posedge clk_sys); #1 ps2_clk_in = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1 ps2_clk_in = 1'b1;
    repeat (100) @(posedge clk_sys);
    wait_drain("glitch");
    check("glitch_key_held", ps2_key, 11'h229);

    send_frame(8'h5A, 1'b0, 1'b0, 4);
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("midreset_key", ps2_key, 11'd0);
    check("midreset_err", {10'd0, frame_err}, 11'd0);
    m_tog = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
    reset_n = 1'b1;
    repeat (20) @(posedge clk_sys);
    send_byte(8'h5A, 1'b0, 1'b0);
    check("after_midreset", ps2_key, 11'h65A);

    for (int n = 0; n < 45; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = 8'hE0;
      else if (sel == 1) b = 8'hF0;
      else if (sel == 2) b = rsp[$urandom_range(0, 5)];
      else               b = 8'($urandom_range(0, 255));
      sel = $urandom_range(0, 9);
      bp = (sel == 0);
      bs = (sel == 1);
      send_byte(b, bp, bs);
    end

    wait_drain("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_encoder.md
Name: ps2_key_encoder

Overview:
- Receives raw PS/2 keyboard serial traffic (clock and data lines, host side, receive only).
- Produces the 11-bit toggle-format key event bus consumed by the core key decoders:
  - bit 10: toggles on every event
  - bit 9: pressed
  - bit 8: extended (E0)
  - bits 7:0: scan code
- Lets a core take a keyboard directly on the user port with the same event semantics the framework delivers.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronized samples required before a filtered line changes level.
- TIMEOUT, 20000: clk_sys cycles allowed between falling edges inside a frame before the frame is aborted (1 ms at 20 MHz).

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_clk_in  in  1  raw PS/2 clock line, asynchronous to clk_sys.
- ps2_dat_in  in  1  raw PS/2 data line, asynchronous to clk_sys.
- ps2_key  out  11  event bus: [10] toggle, [9] pressed, [8] extended, [7:0] code.
- frame_err  out  1  one-cycle pulse on a parity, stop-bit or timeout failure.

Behaviour:
- Clock and reset: one clock (clk_sys). Reset is asynchronous, active-low (reset_n).
- Reset values:
  - ps2_key = 0 and frame_err = 0.
  - FSM = IDLE, ext = 0, brk = 0, timeout counter = 0.
  - Both filtered lines = 1.
- Line conditioning, per line:
  - 2-flop synchronizer, then a filter counter.
  - The filtered output takes the synchronized level only after FILTER_LEN consecutive equal samples.
  - A glitch shorter than FILTER_LEN cycles is invisible.
- A sampling strobe fires for one cycle when filtered clk goes 1 to 0. Data is taken from filtered dat in that same cycle.
- FSM states, one transition per strobe:
  - IDLE: dat = 0 moves to DATA with bitcnt = 0. dat = 1 is a false start and stays in IDLE with no error.
  - DATA: shifts bits in LSB first. After the 8th bit, moves to PARITY.
  - PARITY: stores the parity bit, then moves to STOP.
  - STOP: requires dat = 1 and odd parity (XOR of 8 data bits and parity bit = 1). Either way, returns to IDLE.
- Timeout:
  - The counter clears on every strobe and increments otherwise while the FSM is not IDLE.
  - When the counter reaches TIMEOUT: FSM returns to IDLE, frame_err pulses, ext and brk clear.
  - The counter saturates and does not increment in IDLE.
- Parity or stop failure: frame_err pulses in the cycle after the STOP strobe. No event is emitted; ext and brk clear.
- Good byte B, processed in the cycle after the STOP strobe:
  - B = E0: set ext. No event.
  - B = F0: set brk. No event.
  - B in {00, AA, EE, FA, FE, FF} with ext = 0 and brk = 0: keyboard response, dropped. No event.
  - Otherwise: ps2_key[7:0] = B, [8] = ext, [9] = ~brk, [10] inverted. Then ext and brk clear.
- Latency: ps2_key changes exactly 1 clk_sys cycle after the STOP strobe. [9:0] are stable whenever [10] toggles.
- Prefixes combine: E0 F0 xx gives a released, extended event. F0 E0 xx gives the same.
- Reset mid-frame: the partial frame is discarded, and the next frame must start from IDLE.
- No transmit path: this block never drives the PS/2 lines.

Decomposition:
- Shared package ps2_pkg:
  - Byte constants PS2_EXT = E0, PS2_BRK = F0.
  - The drop-list constants.
  - FSM state enum {IDLE, DATA, PARITY, STOP}.
- Sub-module ps2_line_filter (synchronizer plus FILTER_LEN filter). It is instantiated twice, once per line.

Test Plan:
- Frame 1C, correct parity -> ps2_key = 11'h61C (toggle 1, pressed 1, ext 0), 1 cycle after the stop strobe. frame_err stays 0.
- F0 then 1C after the first event -> ps2_key = 11'h01C (toggle 0, pressed 0). No event between the two bytes.
- E0 75, then E0 F0 75 -> 11'h775, then 11'h175.
- Frame 1C with the parity bit flipped -> frame_err single pulse; ps2_key unchanged. A following good 1C event is not extended or released.
- Clock stops after 4 data bits for TIMEOUT+10 cycles -> frame_err pulse at TIMEOUT. A following frame 29 -> event 0x29 with correct toggle.
- 3-cycle low glitch on ps2_clk_in while idle (FILTER_LEN = 8) -> no state change, no error. reset_n low mid-frame -> all outputs 0; the next full frame decodes correctly.
